// File: rtl/inst_rom_arb_pkg.sv
// Shared constants and helpers for the instruction ROM arbiter.
package inst_rom_arb_pkg;

  // ROM chip-enable encoding
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Default starvation limit and counter width
  localparam int unsigned ARB_MAX_WAIT = 4;
  localparam int unsigned ARB_CNT_W    = 4;

  typedef logic [ARB_CNT_W-1:0] arb_cnt_t;

  // Port 1 wins when it is alone, or when it has lost MAX_WAIT cycles in a row.
  function automatic logic arb_port1_wins(input logic     req0,
                                          input logic     req1,
                                          input arb_cnt_t cnt,
                                          input arb_cnt_t max_wait);
    return req1 && (!req0 || (cnt >= max_wait));
  endfunction

endpackage

// File: rtl/inst_rom_arb.sv
// Two-port arbiter in front of the combinational instruction ROM.
// Port 0 (fetch) has priority; a starvation counter guarantees port 1 service.
// Read data is registered, one cycle after the grant.
module inst_rom_arb
  import inst_rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  output logic              stall_req
);

  localparam arb_cnt_t LP_MAX = arb_cnt_t'(MAX_WAIT);

  arb_cnt_t          r_wait_cnt;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  // Grant decision and ROM drive; reset low suppresses all grants.
  always_comb begin
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    rom_ce   = CHIP_DISABLE;
    rom_addr = '0;
    if (rst) begin
      if (arb_port1_wins(req0, req1, r_wait_cnt, LP_MAX)) begin
        w_gnt1 = 1'b1;
      end else if (req0) begin
        w_gnt0 = 1'b1;
      end
    end
    if (w_gnt0) begin
      rom_ce   = CHIP_ENABLE;
      rom_addr = addr0;
    end else if (w_gnt1) begin
      rom_ce   = CHIP_ENABLE;
      rom_addr = addr1;
    end
  end

  // Starvation counter: counts consecutive port 1 losses, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (w_gnt1 || !req1) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt < LP_MAX) begin
      r_wait_cnt <= r_wait_cnt + arb_cnt_t'(1);
    end
  end

  // Port 0 capture register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rvalid0 <= 1'b0;
      r_rdata0  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0;
      if (w_gnt0) begin
        r_rdata0 <= rom_inst;
      end
    end
  end

  // Port 1 capture register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rvalid1 <= 1'b0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid1 <= w_gnt1;
      if (w_gnt1) begin
        r_rdata1 <= rom_inst;
      end
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign stall_req = rst & req0 & ~w_gnt0;

endmodule

// File: doc/inst_rom_arb.md
# inst_rom_arb

Two-port arbiter that shares the single combinational instruction ROM between the CPU fetch stage (port 0) and a secondary reader (port 1: debug/loader read-back or a data-side ROM read). It sits between `pc_reg`/`if_id` and `inst_rom` and owns the ROM's `ce` and `addr` pins. Port 0 has priority, and a starvation counter guarantees port 1 service. Read data is registered with one-cycle latency, and port 0 losses are reported to `ctrl` as a stall request.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both ports and the ROM (`InstAddrBus`).
- `DATA_W`, 32, data width (`InstBus`).
- `MAX_WAIT`, 4, consecutive lost cycles after which port 1 wins once. Legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req0`  in  1  fetch read request.
- `addr0`  in  ADDR_W  fetch byte address.
- `gnt0`  out  1  port 0 granted this cycle.
- `rvalid0`  out  1  `rdata0` updated (one cycle after `gnt0`).
- `rdata0`  out  DATA_W  port 0 read data.
- `req1`, `addr1`, `gnt1`, `rvalid1`, `rdata1`: same as port 0, for port 1.
- `rom_ce`  out  1  ROM chip enable (ChipEnable/ChipDisable).
- `rom_addr`  out  ADDR_W  ROM address.
- `rom_inst`  in  DATA_W  ROM data, combinational from `rom_addr`.
- `stall_req`  out  1  to `ctrl`: `req0` is pending and not granted.

## Operation
Grant decision, combinational, at most one grant per cycle:
- `req0 & !req1` grants port 0.
- `req1 & !req0` grants port 1.
- Both requests, with `wait_cnt < MAX_WAIT`, grants port 0.
- Both requests, with `wait_cnt == MAX_WAIT`, grants port 1.
- `rst==0` forces `gnt0 = gnt1 = 0`.

Starvation counter `wait_cnt` (4-bit, registered):
- Increments when `req1 & !gnt1`.
- Clears when `gnt1` or `!req1`.
- Saturates at `MAX_WAIT`; never wraps.

ROM drive:
- `rom_ce = ChipEnable` iff either grant.
- `rom_addr` = granted port's address, else `ZeroWord`.

Data capture:
- On the edge after `gntN`: `rdataN <= rom_inst` and `rvalidN <= 1`.
- Otherwise `rvalidN <= 0` and `rdataN` holds its last value.

Requester rules:
- Hold `reqN` until `gntN`.
- The address may change while waiting; the address present in the grant cycle is the one read.
- A request dropped before grant is discarded with no side effect.

`stall_req = req0 & !gnt0`, combinational.

No address decoding or range checking: the ROM's own index slicing applies.

## Timing
- Request to grant: 0 cycles when uncontested.
- Grant to data: 1 cycle (`rvalid` registered).
- Back-to-back grants to the same port give `rvalid` every cycle.
- Worst-case port 1 wait: `MAX_WAIT` cycles.
- Worst-case port 0 wait: 1 cycle per `MAX_WAIT+1` window.
- Registered reset values on `rst==0` at the edge: `rvalid0 = rvalid1 = 0`, `rdata0 = rdata1 = ZeroWord`, `wait_cnt = 0`.
- Combinational outputs while `rst==0`: `gnt0 = gnt1 = 0`, `rom_ce = ChipDisable`, `rom_addr = ZeroWord`, `stall_req = 0`.
- Reset asserted mid-operation: the pending `rvalid` for the current grant is dropped, and the counter restarts at 0.
- Reset released: arbitration resumes the same cycle.
- Simultaneous requests in the cycle `wait_cnt` reaches `MAX_WAIT` (registered): the decision uses the registered value, so port 1 wins on the following cycle.

## Structure
- Add to `defines.v`: `ArbMaxWait` (default 4) and `ArbCntBus` (3:0).
- Reuse the existing macros `ChipEnable`, `ChipDisable`, `ZeroWord`, `InstAddrBus`, `InstBus`.
- Single module, no sub-module. Counter, grant logic and two capture registers are inline, each in its own always block.
- Top-level integration replaces the direct `pc_reg`→`inst_rom` connection. `stall_req` ORs into `ctrl`'s stall source alongside `stallreq_from_id`/`ex`.

## Test plan
- Reset: hold `rst=0` with both req high for 3 cycles. Expect all grants 0, `rom_ce` disabled, `stall_req=0`, `rdata*=0`.
- Lone fetch: `req0=1`, `addr0=0x8` with ROM word 2 = `0x34011100`. Expect `gnt0` the same cycle and `rom_addr=0x8`; next cycle `rvalid0=1`, `rdata0=0x34011100`.
- Starvation: both req held continuously, `MAX_WAIT=4`. Expect `gnt0` for 4 cycles, `gnt1` on the 5th with `stall_req=1` that cycle, then the pattern repeats with period 5.
- Counter clear: `req1` high 3 cycles under contention, drop 1 cycle, re-raise. Expect the counter restarts at 0 and port 1 waits a further 4 cycles.
- Mid-read reset: grant port 1 at cycle n, assert `rst=0` at cycle n+1 edge. Expect `rvalid1=0` and `rdata1=0` at n+1; after release, port 0 is granted immediately.
- Address change while waiting: `addr1` changes from 0x10 to 0x14 before its grant. Expect `rdata1` equals ROM word 5.
